// File: rtl/mux_nto1_pipe_array_pkg.sv
// Shared types and helpers for the pipelined multi-lane operand selector.
package mux_pipe_pkg;

  localparam int unsigned DEF_NUM_IN = 16;
  localparam int unsigned MAX_W      = 64;

  function automatic int unsigned sel_width(input int unsigned num_in);
    return $clog2(num_in + 1);
  endfunction

  // Select code that always yields a zero operand.
  localparam int unsigned ZERO_SEL = DEF_NUM_IN;

  typedef logic [sel_width(DEF_NUM_IN)-1:0] lane_sel_t;

  // Callers truncate the result to their operand width.
  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] v);
    return (~v) + MAX_W'(1);
  endfunction

endpackage

// File: rtl/mux_nto1_zero.sv
// One output lane: pick an operand (or zero for out-of-range codes), then optionally negate.
module mux_nto1_zero
  import mux_pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_IN     = 16,
  parameter int unsigned SEL_W      = 5
) (
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0] i_vec,
  input  logic [SEL_W-1:0]                  i_sel,
  input  logic                              i_neg,
  output logic [DATA_WIDTH-1:0]             o_res
);

  logic [DATA_WIDTH-1:0] w_sel_v;

  // Compare-based select: codes >= NUM_IN match nothing and fall through to zero.
  always_comb begin
    w_sel_v = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (i_sel == SEL_W'(i)) w_sel_v = i_vec[i];
    end
  end

  assign o_res = i_neg ? DATA_WIDTH'(twos_neg(MAX_W'(w_sel_v))) : w_sel_v;

endmodule

// File: rtl/mux_nto1_pipe_array.sv
// Two-stage handshaked selector: S1 captures the operand beat, S2 registers per-lane results.
module mux_nto1_pipe_array
  import mux_pipe_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned NUM_IN     = 16,
  parameter  int unsigned NUM_LANE   = 4,
  localparam int unsigned SEL_W      = sel_width(NUM_IN)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_IN-1:0][DATA_WIDTH-1:0]   vec_in,
  input  logic [NUM_LANE-1:0][SEL_W-1:0]      sel_in,
  input  logic [NUM_LANE-1:0]                 neg_in,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_LANE-1:0][DATA_WIDTH-1:0] lane_out
);

  logic                                r_s1_valid;
  logic [NUM_IN-1:0][DATA_WIDTH-1:0]   r_s1_vec;
  logic [NUM_LANE-1:0][SEL_W-1:0]      r_s1_sel;
  logic [NUM_LANE-1:0]                 r_s1_neg;
  logic                                r_s2_valid;
  logic [NUM_LANE-1:0][DATA_WIDTH-1:0] r_lane_out;

  logic                                w_s1_load;
  logic                                w_s2_load;
  logic [NUM_LANE-1:0][DATA_WIDTH-1:0] w_lane;

  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_s1_load = in_valid && in_ready;

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    mux_nto1_zero #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_IN     (NUM_IN),
      .SEL_W      (SEL_W)
    ) u_mux (
      .i_vec (r_s1_vec),
      .i_sel (r_s1_sel[g]),
      .i_neg (r_s1_neg[g]),
      .o_res (w_lane[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_vec   <= '0;
      r_s1_sel   <= '0;
      r_s1_neg   <= '0;
      r_s2_valid <= 1'b0;
      r_lane_out <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_vec <= vec_in;
        r_s1_sel <= sel_in;
        r_s1_neg <= neg_in;
      end
      if (w_s1_load)      r_s1_valid <= 1'b1;
      else if (w_s2_load) r_s1_valid <= 1'b0;

      // S2 result only changes on a load, so a stalled beat stays stable.
      if (w_s2_load) begin
        r_s2_valid <= 1'b1;
        r_lane_out <= w_lane;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign lane_out  = r_lane_out;

endmodule

// File: tb/tb_mux_nto1_pipe_array.sv
// Randomised and directed bench for mux_nto1_pipe_array with a queue-based reference model.
module tb_mux_nto1_pipe_array;

  localparam int DW = 8;
  localparam int NI = 16;
  localparam int NL = 4;
  localparam int SW = $clog2(NI + 1);

  typedef logic [NL-1:0][DW-1:0] lanes_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [NI-1:0][DW-1:0]    vec_in;
  logic [NL-1:0][SW-1:0]    sel_in;
  logic [NL-1:0]            neg_in;
  logic                     out_valid;
  logic                     out_ready;
  lanes_t                   lane_out;

  always #5 clk = ~clk;

  mux_nto1_pipe_array #(
    .DATA_WIDTH (DW),
    .NUM_IN     (NI),
    .NUM_LANE   (NL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec_in    (vec_in),
    .sel_in    (sel_in),
    .neg_in    (neg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_out  (lane_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: arithmetic selection and negation straight from the rules.
  function automatic lanes_t model(input logic [NI-1:0][DW-1:0] v,
                                   input logic [NL-1:0][SW-1:0] s,
                                   input logic [NL-1:0] n);
    lanes_t r;
    for (int l = 0; l < NL; l++) begin
      int code, val;
      code = int'(s[l]);
      val  = (code < NI) ? int'(v[code]) : 0;
      if (n[l]) val = -val;
      r[l] = val[DW-1:0];
    end
    return r;
  endfunction

  lanes_t exp_q[$];
  int     exp_cyc[$];
  lanes_t out_log[$];
  int     cyc = 0;
  int     out_cnt = 0;
  bit     lat_chk = 0;
  bit     held_valid = 0;
  lanes_t held_data;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      exp_cyc.delete();
      held_valid = 0;
    end else begin
      if (held_valid) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(lane_out), 64'(held_data));
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        out_log.push_back(lane_out);
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          lanes_t e;
          int c;
          e = exp_q.pop_front();
          c = exp_cyc.pop_front();
          check("lane_out", 64'(lane_out), 64'(e));
          if (lat_chk) check("latency", 64'(cyc - c), 64'd2);
        end
      end
      held_valid = out_valid && !out_ready;
      held_data  = lane_out;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(vec_in, sel_in, neg_in));
        exp_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, snap;
    bit low_seen, acc;

    // 1: reset held two cycles with in_valid asserted
    reset = 1; in_valid = 1; out_ready = 1;
    for (int i = 0; i < NI; i++) vec_in[i] = DW'($urandom);
    sel_in = '0; neg_in = '0;
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_lane_out", 64'(lane_out), 64'd0);
    reset = 0; in_valid = 0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // 2: basic selection including the zero code
    for (int i = 0; i < NI; i++) vec_in[i] = DW'(i + 1);
    sel_in[0] = 0; sel_in[1] = 5; sel_in[2] = 15; sel_in[3] = 16;
    neg_in = 4'b0000; in_valid = 1;
    step();
    in_valid = 0;
    check("basic_lat1", 64'(out_valid), 64'd0);
    step();
    check("basic_valid", 64'(out_valid), 64'd1);
    check("basic_data", 64'(lane_out), 64'h00_10_06_01);
    step();
    check("basic_one_cycle", 64'(out_valid), 64'd0);

    // 3: negate with wrap and zero codes
    vec_in[3] = 8'h80; vec_in[4] = 8'h05;
    sel_in[0] = 3; sel_in[1] = 4; sel_in[2] = 16; sel_in[3] = 31;
    neg_in = 4'b1111; in_valid = 1;
    step();
    in_valid = 0;
    step();
    check("neg_valid", 64'(out_valid), 64'd1);
    check("neg_data", 64'(lane_out), 64'h00_00_FB_80);
    step(); step();

    // 4: back-pressure, tag in vec[0]
    out_log.delete();
    sel_in = '0; neg_in = '0;
    k = 0; low_seen = 0;
    for (int t = 0; t < 30; t++) begin
      out_ready = !(t >= 3 && t <= 6);
      in_valid  = (k < 6);
      vec_in[0] = DW'(k);
      #1;
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) low_seen = 1;
      step();
      if (acc) k++;
    end
    in_valid = 0; out_ready = 1;
    check("bp_in_ready_low", 64'(low_seen), 64'd1);
    check("bp_count", 64'(out_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < out_log.size(); i++)
      check("bp_order", 64'(out_log[i]), 64'({NL{DW'(i)}}));

    // 5: full-rate random stream
    snap = out_cnt;
    lat_chk = 1; out_ready = 1;
    for (int t = 0; t < 32; t++) begin
      for (int i = 0; i < NI; i++) vec_in[i] = DW'($urandom);
      for (int l = 0; l < NL; l++) sel_in[l] = SW'($urandom_range(0, 31));
      neg_in = NL'($urandom);
      in_valid = 1;
      #1;
      check("fr_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 0;
    repeat (4) step();
    lat_chk = 0;
    check("fr_count", 64'(out_cnt - snap), 64'd32);
    check("fr_drained", 64'(exp_q.size()), 64'd0);

    // 6: reset with both stages full and output stalled
    out_ready = 0;
    for (int i = 0; i < NI; i++) vec_in[i] = 8'hA5;
    sel_in = '0; neg_in = '0;
    in_valid = 1;
    step(); step();
    in_valid = 0;
    #1;
    check("mf_full_in_ready", 64'(in_ready), 64'd0);
    check("mf_full_valid", 64'(out_valid), 64'd1);
    reset = 1;
    step();
    check("mf_rst_valid", 64'(out_valid), 64'd0);
    check("mf_rst_data", 64'(lane_out), 64'd0);
    reset = 0; out_ready = 1;
    snap = out_cnt;
    repeat (4) step();
    check("mf_no_ghost", 64'(out_cnt - snap), 64'd0);
    check("mf_valid_low", 64'(out_valid), 64'd0);

    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
